// File: rtl/effect_frame_encoder_if.sv
// Request/frame bus between an effect source, the frame encoder and the
// breadboard program-frame sink.
//   req_valid/req_ready/req_cmd : one-hot effect request handshake
//   flush                       : close the current partial frame
//   frame_valid/frame_ready     : completed-frame handshake
//   frame_data/frame_count      : four packed opcodes and real-slot count
//   err_pulse/err_count         : illegal-request pulse and saturating tally
interface effect_frame_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_cmd;
  logic        flush;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic [2:0]  frame_count;
  logic        err_pulse;
  logic [7:0]  err_count;

  modport master (
    output req_valid, req_cmd, flush, frame_ready,
    input  req_ready, frame_valid, frame_data, frame_count, err_pulse, err_count
  );

  modport slave (
    input  req_valid, req_cmd, flush, frame_ready,
    output req_ready, frame_valid, frame_data, frame_count, err_pulse, err_count
  );
endinterface

// File: rtl/effect_frame_encoder.sv
// Packs one-hot effect requests into 16-bit four-slot program frames.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : request handshake in, frame handshake out, error reporting
// Each legal request becomes a 4-bit opcode in the next free slot; a frame is
// emitted when four slots are full, on flush, or after IDLE_TIMEOUT idle
// cycles. Unused slots carry NOOP so 0000 never reaches the receiver.
module effect_frame_encoder #(
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  effect_frame_encoder_if.slave bus
);

  localparam int unsigned SLOT_W  = 4;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned IDLE_W  = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Opcodes 1,2,3,4,5,6,8,9,10,12,13 are the only requestable effects.
  localparam logic [FRAME_W-1:0] LEGAL_MASK = 16'h377E;
  localparam logic [FRAME_W-1:0] NOOP_FRAME = 16'h2222;
  localparam logic [CNT_W-1:0]   FULL_CNT   = 3'd4;
  localparam logic [ERR_W-1:0]   ERR_MAX    = 8'hFF;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [FRAME_W-1:0] slots_q, slots_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic               req_ready_c;
  logic               accept;
  logic               cmd_legal;
  logic [SLOT_W-1:0]  op;
  logic               legal_acc;
  logic               illegal_acc;
  logic [CNT_W-1:0]   cnt_post;
  logic [FRAME_W-1:0] slots_post;
  logic               idle_inc;
  logic               timeout_hit;

  // One-hot index to opcode; only meaningful when the command is legal.
  function automatic logic [SLOT_W-1:0] cmd_to_op(input logic [FRAME_W-1:0] cmd);
    logic [SLOT_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(FRAME_W); i++) begin
      if (cmd[i]) r = SLOT_W'(i);
    end
    return r;
  endfunction

  // Ready is a state decode, forced low while reset is held.
  assign req_ready_c = (state_q == FILL) && !rst;

  // Request classification and post-accept slot contents.
  always_comb begin
    accept      = bus.req_valid && (state_q == FILL);
    cmd_legal   = $onehot(bus.req_cmd) && ((bus.req_cmd & LEGAL_MASK) != '0);
    op          = cmd_to_op(bus.req_cmd);
    legal_acc   = accept && cmd_legal;
    illegal_acc = accept && !cmd_legal;
    cnt_post    = cnt_q + CNT_W'(legal_acc);
    slots_post  = slots_q;
    if (legal_acc) slots_post[{cnt_q[1:0], 2'b00} +: SLOT_W] = op;
    idle_inc    = (IDLE_TIMEOUT != 0) && (state_q == FILL) && (cnt_q != '0) && !legal_acc;
    // Fires on the edge where the idle count would reach IDLE_TIMEOUT.
    timeout_hit = idle_inc && ((32'(idle_q) + 32'd1) == 32'(IDLE_TIMEOUT));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idle_d        = idle_q;
    slots_d       = slots_q;
    frame_data_d  = frame_data_q;
    frame_count_d = frame_count_q;
    err_pulse_d   = 1'b0;
    err_count_d   = err_count_q;

    if (illegal_acc) begin
      err_pulse_d = 1'b1;
      if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_W'(1);
    end

    case (state_q)
      FILL: begin
        if ((cnt_post == FULL_CNT) || (bus.flush && (cnt_post != '0)) || timeout_hit) begin
          // Slot register is pre-loaded with NOOP, so padding is implicit.
          state_d       = SEND;
          frame_data_d  = slots_post;
          frame_count_d = cnt_post;
          cnt_d         = '0;
          slots_d       = NOOP_FRAME;
          idle_d        = '0;
        end else begin
          cnt_d   = cnt_post;
          slots_d = slots_post;
          if (legal_acc || (cnt_post == '0)) idle_d = '0;
          else if (idle_inc)                 idle_d = idle_q + IDLE_W'(1);
        end
      end
      SEND: begin
        if (bus.frame_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      cnt_q         <= '0;
      idle_q        <= '0;
      slots_q       <= NOOP_FRAME;
      frame_data_q  <= NOOP_FRAME;
      frame_count_q <= '0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      slots_q       <= slots_d;
      frame_data_q  <= frame_data_d;
      frame_count_q <= frame_count_d;
      err_pulse_q   <= err_pulse_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.frame_valid = (state_q == SEND);
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_count = frame_count_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_effect_frame_encoder.sv
// Directed self-checking bench for effect_frame_encoder (IDLE_TIMEOUT = 8).
module tb_effect_frame_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  effect_frame_encoder_if bus ();

  effect_frame_encoder #(.IDLE_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] cmd);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_cmd     = '0;
    bus.flush       = 1'b0;
    bus.frame_ready = 1'b1;

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_req_ready",   32'(bus.req_ready),   32'd0);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_frame_data",  32'(bus.frame_data),  32'h2222);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    check("rst_err_pulse",   32'(bus.err_pulse),   32'd0);
    check("rst_err_count",   32'(bus.err_count),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Back-to-back legal requests: FOG GREEN BOO MOVEJAW
    send(16'h0008);
    send(16'h0010);
    send(16'h0400);
    check("b2b_not_yet", 32'(bus.frame_valid), 32'd0);
    send(16'h2000);
    check("b2b_valid",     32'(bus.frame_valid), 32'd1);
    check("b2b_data",      32'(bus.frame_data),  32'hDA43);
    check("b2b_count",     32'(bus.frame_count), 32'd4);
    check("b2b_req_ready", 32'(bus.req_ready),   32'd0);
    tick();
    check("b2b_released",  32'(bus.frame_valid), 32'd0);
    check("b2b_ready_back", 32'(bus.req_ready),  32'd1);

    // Partial frame closed by flush: PURPLE SCREAMING
    send(16'h0020);
    send(16'h0100);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", 32'(bus.frame_valid), 32'd1);
    check("flush_data",  32'(bus.frame_data),  32'h2285);
    check("flush_count", 32'(bus.frame_count), 32'd2);
    tick();
    check("flush_released", 32'(bus.frame_valid), 32'd0);

    // Flush with an empty frame does nothing
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("empty_flush_a", 32'(bus.frame_valid), 32'd0);
    tick();
    check("empty_flush_b", 32'(bus.frame_valid), 32'd0);

    // Accept and flush in the same cycle includes the accepted opcode
    bus.flush = 1'b1;
    send(16'h0008);
    bus.flush = 1'b0;
    check("accflush_valid", 32'(bus.frame_valid), 32'd1);
    check("accflush_data",  32'(bus.frame_data),  32'h2223);
    check("accflush_count", 32'(bus.frame_count), 32'd1);
    tick();

    // Idle timeout: WAVEHANDS then idle for 8 edges
    send(16'h1000);
    repeat (7) tick();
    check("timeout_early", 32'(bus.frame_valid), 32'd0);
    tick();
    check("timeout_valid", 32'(bus.frame_valid), 32'd1);
    check("timeout_data",  32'(bus.frame_data),  32'h222C);
    check("timeout_count", 32'(bus.frame_count), 32'd1);
    tick();
    check("timeout_released", 32'(bus.frame_valid), 32'd0);

    // Illegal requests back to back
    send(16'h0001);
    check("ill0_pulse", 32'(bus.err_pulse), 32'd1);
    check("ill0_count", 32'(bus.err_count), 32'd1);
    send(16'h0018);
    check("ill1_pulse", 32'(bus.err_pulse), 32'd1);
    check("ill1_count", 32'(bus.err_count), 32'd2);
    send(16'h0000);
    check("ill2_pulse", 32'(bus.err_pulse), 32'd1);
    check("ill2_count", 32'(bus.err_count), 32'd3);
    send(16'h8000);
    check("ill3_pulse", 32'(bus.err_pulse), 32'd1);
    check("ill3_count", 32'(bus.err_count), 32'd4);
    tick();
    check("ill_pulse_drop", 32'(bus.err_pulse), 32'd0);
    // No slot filled: flush must not produce a frame, no timeout either
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("ill_no_slot", 32'(bus.frame_valid), 32'd0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(16'h0080);
    check("sat_pulse", 32'(bus.err_pulse), 32'd1);
    check("sat_count", 32'(bus.err_count), 32'd255);
    tick();

    // Backpressure: RESET NOOP ORANGE CACKLING held with frame_ready low
    bus.frame_ready = 1'b0;
    send(16'h0002);
    send(16'h0004);
    send(16'h0040);
    send(16'h0200);
    check("bp_valid", 32'(bus.frame_valid), 32'd1);
    check("bp_data",  32'(bus.frame_data),  32'h9621);
    bus.req_valid = 1'b1;
    bus.req_cmd   = 16'h0008;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus.frame_valid), 32'd1);
      check("bp_hold_data",  32'(bus.frame_data),  32'h9621);
      check("bp_hold_count", 32'(bus.frame_count), 32'd4);
      check("bp_hold_ready", 32'(bus.req_ready),   32'd0);
    end
    bus.frame_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.frame_valid), 32'd0);
    check("bp_release_ready", 32'(bus.req_ready),   32'd1);
    tick();
    bus.req_valid = 1'b0;
    send(16'h0010);
    send(16'h0400);
    check("bp_next_not_yet", 32'(bus.frame_valid), 32'd0);
    send(16'h2000);
    check("bp_next_valid", 32'(bus.frame_valid), 32'd1);
    check("bp_next_data",  32'(bus.frame_data),  32'hDA43);
    tick();

    // Reset mid-frame discards the partial slots
    send(16'h0008);
    send(16'h0010);
    send(16'h0400);
    rst = 1'b1;
    #1;
    check("midrst_valid",     32'(bus.frame_valid), 32'd0);
    check("midrst_data",      32'(bus.frame_data),  32'h2222);
    check("midrst_err_count", 32'(bus.err_count),   32'd0);
    check("midrst_req_ready", 32'(bus.req_ready),   32'd0);
    tick();
    rst = 1'b0;
    send(16'h0020);
    send(16'h0040);
    send(16'h0100);
    send(16'h1000);
    check("midrst_new_valid", 32'(bus.frame_valid), 32'd1);
    check("midrst_new_data",  32'(bus.frame_data),  32'hC865);
    check("midrst_new_count", 32'(bus.frame_count), 32'd4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/effect_frame_encoder.md
# effect_frame_encoder

Transmit-side counterpart of the decoration breadboard. Accepts one effect request per handshake as a one-hot 16-bit command, converts it to the 4-bit effect opcode, and packs four opcodes into the 16-bit four-channel program frame that the breadboard mux/decoder consumes. Partial frames are padded with NOOP on explicit flush or on idle timeout. Completed frames are held on a valid/ready output until the downstream accepts them.

## Interface
- IDLE_TIMEOUT, 8: consecutive non-accepting cycles, with at least one slot filled, before an automatic flush; 0 disables the auto-flush.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request this cycle.
- req_cmd  in  16  one-hot effect; bit i requests opcode i.
- flush  in  1  close the current partial frame (level, sampled each clock).
- frame_valid  out  1  frame_data holds a complete frame.
- frame_ready  in  1  downstream accepts the frame.
- frame_data  out  16  slot k in bits [4k+3:4k]; slot 0 is in bits [3:0].
- frame_count  out  3  number of real (non-pad) slots in the frame, 1..4.
- err_pulse  out  1  one-cycle pulse when an accepted request is illegal.
- err_count  out  8  illegal requests since reset; saturates at 255.

## Operation
- Opcode map: RESET 1, NOOP 2, FOG 3, GREEN 4, PURPLE 5, ORANGE 6, SCREAMING 8, CACKLING 9, BOO 10, WAVEHANDS 12, MOVEJAW 13.
- Legal req_cmd: exactly one bit set, at an index in {1,2,3,4,5,6,8,9,10,12,13}.
- Illegal req_cmd: zero, multi-hot, bit 0 (ON), bit 7, 11, 14 or 15.
- ON is illegal because 0000 in slot 0 holds the receiver's channel pointer in reset. The encoder never emits 0000 in any slot.
- States:
  - FILL: req_ready=1, frame_valid=0.
  - SEND: req_ready=0, frame_valid=1.
- Accept happens when req_valid && req_ready.
  - Legal accept: write the opcode into slot[cnt], cnt++, clear the idle counter.
  - Illegal accept: the request is consumed and dropped, err_pulse=1 next cycle, err_count++ (saturating), cnt unchanged.
- FILL to SEND transitions:
  - cnt reaches 4.
  - flush=1 with post-accept cnt>=1.
  - Idle counter reaches IDLE_TIMEOUT with cnt>=1.
  - On entry to SEND, slots >= cnt are filled with NOOP (0x2), frame_count is set to cnt, and cnt is cleared.
- flush with cnt 0 and no legal accept in the same cycle is ignored.
- Idle counter:
  - Increments each FILL cycle with cnt>=1 and no legal accept.
  - Held at 0 when cnt=0.
  - An illegal accept does not clear it.
- SEND to FILL happens when frame_ready=1. frame_data and frame_count hold their values until the next frame loads.
- Same-cycle legal accept and flush: the accepted opcode is included, then the frame is padded.
- Reset values:
  - state FILL, cnt 0, idle counter 0.
  - frame_valid 0, frame_data 16'h2222, frame_count 0.
  - err_pulse 0, err_count 0.
  - req_ready 0 while rst is asserted.
- Reset mid-frame discards all slots and any pending frame.

## Timing
- All outputs are registered except req_ready, which is decoded directly from state.
- The 4th legal accept at edge N gives frame_valid=1 after edge N.
- A flush or timeout sampled at edge N gives frame_valid=1 after edge N.
- frame_ready=1 while frame_valid=1 at edge M:
  - frame_valid=0 and req_ready=1 after edge M.
  - The earliest next accept is edge M+1.
- Throughput: at most one frame per 5 cycles with back-to-back requests (4 accepts plus 1 SEND cycle).
- While frame_valid=1 and frame_ready=0, frame_data and frame_count are stable, and no request is accepted regardless of req_valid.
- Timeout: with the last legal accept at edge N and no further accepts, frame_valid rises after edge N+IDLE_TIMEOUT.
- err_pulse is high for exactly one cycle per illegal accept. Back-to-back illegal accepts give back-to-back pulses.

## Test plan
- Back-to-back legal requests, frame_ready=1:
  - Stimulus: 16'h0008, 16'h0010, 16'h0400, 16'h2000 on consecutive edges.
  - Required: frame_valid one cycle after the 4th accept, frame_data 16'hDA43, frame_count 4, frame_valid low the following cycle.
- Partial frame with flush:
  - Stimulus: 16'h0020 then 16'h0100, then flush=1.
  - Required: frame_data 16'h2285, frame_count 2.
  - Also: flush pulsed with cnt 0 produces no frame.
- Idle timeout, IDLE_TIMEOUT=8:
  - Stimulus: single request 16'h1000, then idle.
  - Required: frame_valid rises 8 edges after the accept, frame_data 16'h222C, frame_count 1.
- Illegal requests:
  - Stimulus: 16'h0001, 16'h0018, 16'h0000, 16'h8000.
  - Required: four err_pulses, err_count 4, no slot filled.
  - Also: 300 illegal requests leave err_count at 255.
- Backpressure:
  - Stimulus: complete a frame, hold frame_ready=0 for 5 cycles with req_valid=1.
  - Required: frame_data stable, req_ready 0, no accept.
  - Also: frame_ready=1 releases, and the next request is accepted one edge later.
- Reset mid-frame:
  - Stimulus: assert rst after 3 legal accepts.
  - Required: immediately frame_valid 0, frame_data 16'h2222, err_count 0.
  - Also: after deassert, 4 new requests produce a frame containing only the new opcodes.
